// File: rtl/ram_loader.sv
`default_nettype none
// ============================================================================
// Module   : ram_loader
// Purpose  : Streams source bytes into program RAM while holding the CPU;
//            optional running checksum with RAM_LOADER_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module ram_loader #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 4,
    parameter int RAM_LENGTH    = 16
) (
    input  logic                     i_SYS_CLOCK,
    input  logic                     i_RESET,
    input  logic                     i_LOAD_START,
    input  logic                     i_LOAD_ABORT,
    input  logic [DATA_WIDTH-1:0]    i_DATA,
    input  logic                     i_DATA_VALID,
    output logic                     o_DATA_READY,
    output logic [ADDRESS_WIDTH-1:0] o_RAM_ADDR,
    output logic [DATA_WIDTH-1:0]    o_RAM_DATA,
    output logic                     o_RAM_WRITE,
    output logic                     o_CPU_HOLD,
    output logic                     o_CPU_CLEAR,
    output logic                     o_BUSY,
    output logic                     o_DONE,
`ifdef RAM_LOADER_CHECKSUM_EN
    output logic [DATA_WIDTH-1:0]    o_CHECKSUM,
`endif
    output logic [ADDRESS_WIDTH:0]   o_COUNT
);

    localparam logic [ADDRESS_WIDTH-1:0] c_LAST_ADDR = ADDRESS_WIDTH'(RAM_LENGTH - 1);
    localparam logic [ADDRESS_WIDTH:0]   c_LEN_CNT   = (ADDRESS_WIDTH + 1)'(RAM_LENGTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCEPT  = 2'd1,
        S_WRITE   = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t                   r_state_q, w_state_d;
    logic [ADDRESS_WIDTH-1:0] r_addr_q,  w_addr_d;
    logic [ADDRESS_WIDTH:0]   r_count_q, w_count_d;
    logic [DATA_WIDTH-1:0]    r_data_q,  w_data_d;
    logic                     r_hold_q;
    logic                     r_write_q;
    logic                     r_release_q;
`ifdef RAM_LOADER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0]    r_sum_q,   w_sum_d;
`endif

    always_comb begin
        w_state_d = r_state_q;
        w_addr_d  = r_addr_q;
        w_count_d = r_count_q;
        w_data_d  = r_data_q;
`ifdef RAM_LOADER_CHECKSUM_EN
        w_sum_d   = r_sum_q;
`endif
        case (r_state_q)
            S_IDLE: begin
                if (i_LOAD_START) begin
                    w_state_d = S_ACCEPT;
                    w_addr_d  = '0;
                    w_count_d = '0;
`ifdef RAM_LOADER_CHECKSUM_EN
                    w_sum_d   = '0;
`endif
                end
            end
            S_ACCEPT: begin
                // Abort has priority over a byte offered in the same cycle.
                if (i_LOAD_ABORT) begin
                    w_state_d = S_RELEASE;
                end else if (i_DATA_VALID) begin
                    w_data_d  = i_DATA;
                    w_state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (r_count_q < c_LEN_CNT) begin
                    w_count_d = r_count_q + 1'b1;
                end
`ifdef RAM_LOADER_CHECKSUM_EN
                w_sum_d = r_sum_q + r_data_q;
`endif
                if ((r_addr_q == c_LAST_ADDR) || i_LOAD_ABORT) begin
                    w_state_d = S_RELEASE;
                end else begin
                    w_addr_d  = r_addr_q + 1'b1;
                    w_state_d = S_ACCEPT;
                end
            end
            S_RELEASE: begin
                w_state_d = S_IDLE;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    // Status flags are registered from the next state so they align with it.
    always_ff @(posedge i_SYS_CLOCK or posedge i_RESET) begin
        if (i_RESET) begin
            r_state_q   <= S_IDLE;
            r_addr_q    <= '0;
            r_count_q   <= '0;
            r_data_q    <= '0;
            r_hold_q    <= 1'b0;
            r_write_q   <= 1'b0;
            r_release_q <= 1'b0;
`ifdef RAM_LOADER_CHECKSUM_EN
            r_sum_q     <= '0;
`endif
        end else begin
            r_state_q   <= w_state_d;
            r_addr_q    <= w_addr_d;
            r_count_q   <= w_count_d;
            r_data_q    <= w_data_d;
            r_hold_q    <= (w_state_d != S_IDLE);
            r_write_q   <= (w_state_d == S_WRITE);
            r_release_q <= (w_state_d == S_RELEASE);
`ifdef RAM_LOADER_CHECKSUM_EN
            r_sum_q     <= w_sum_d;
`endif
        end
    end

    assign o_DATA_READY = (r_state_q == S_ACCEPT) & ~i_LOAD_ABORT;
    assign o_RAM_ADDR   = r_addr_q;
    assign o_RAM_DATA   = r_data_q;
    assign o_RAM_WRITE  = r_write_q;
    assign o_CPU_HOLD   = r_hold_q;
    assign o_BUSY       = r_hold_q;
    assign o_CPU_CLEAR  = r_release_q;
    assign o_DONE       = r_release_q;
    assign o_COUNT      = r_count_q;
`ifdef RAM_LOADER_CHECKSUM_EN
    assign o_CHECKSUM   = r_sum_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ram_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_loader
// Purpose  : Self-checking bench for ram_loader against a session-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_loader;

    localparam int c_LEN = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] data = 8'h00;
    logic       valid = 1'b0;
    logic       ready, wr, hold, clear, busy, done;
    logic [3:0] addr;
    logic [7:0] rdata;
    logic [4:0] count;
`ifdef RAM_LOADER_CHECKSUM_EN
    logic [7:0] checksum;
`endif

    ram_loader #(.DATA_WIDTH(8), .ADDRESS_WIDTH(4), .RAM_LENGTH(c_LEN)) dut (
        .i_SYS_CLOCK (clk),
        .i_RESET     (rst),
        .i_LOAD_START(start),
        .i_LOAD_ABORT(abort),
        .i_DATA      (data),
        .i_DATA_VALID(valid),
        .o_DATA_READY(ready),
        .o_RAM_ADDR  (addr),
        .o_RAM_DATA  (rdata),
        .o_RAM_WRITE (wr),
        .o_CPU_HOLD  (hold),
        .o_CPU_CLEAR (clear),
        .o_BUSY      (busy),
        .o_DONE      (done),
`ifdef RAM_LOADER_CHECKSUM_EN
        .o_CHECKSUM  (checksum),
`endif
        .o_COUNT     (count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Session model: phase 0 idle, 1 waiting for a byte, 2 writing, 3 releasing.
    int         m_phase = 0;
    int         m_addr  = 0;
    int         m_count = 0;
    logic [7:0] m_data  = 8'h00;
    logic [7:0] m_sum   = 8'h00;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase <= 0;
            m_addr  <= 0;
            m_count <= 0;
            m_data  <= 8'h00;
            m_sum   <= 8'h00;
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_phase <= 1;
                    m_addr  <= 0;
                    m_count <= 0;
                    m_sum   <= 8'h00;
                end
                1: if (abort) m_phase <= 3;
                   else if (valid) begin
                       m_data  <= data;
                       m_phase <= 2;
                   end
                2: begin
                    m_count <= (m_count + 1 > c_LEN) ? c_LEN : m_count + 1;
                    m_sum   <= m_sum + m_data;
                    if (m_addr == c_LEN - 1 || abort) m_phase <= 3;
                    else begin
                        m_addr  <= m_addr + 1;
                        m_phase <= 1;
                    end
                end
                default: m_phase <= 0;
            endcase
        end
    end

    // Per-cycle comparison plus a log of every observed write.
    int cyc = 0;
    int n_clr = 0;
    int n_done = 0;
    int wr_addr[$];
    int wr_cyc[$];

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            chk("ready", {31'd0, ready}, {31'd0, (m_phase == 1) && !abort});
            chk("ram_write", {31'd0, wr}, {31'd0, m_phase == 2});
            chk("cpu_hold", {31'd0, hold}, {31'd0, m_phase != 0});
            chk("busy", {31'd0, busy}, {31'd0, m_phase != 0});
            chk("cpu_clear", {31'd0, clear}, {31'd0, m_phase == 3});
            chk("done", {31'd0, done}, {31'd0, m_phase == 3});
            chk("count", {27'd0, count}, m_count);
            chk("ram_addr", {28'd0, addr}, m_addr);
            chk("ram_data", {24'd0, rdata}, {24'd0, m_data});
`ifdef RAM_LOADER_CHECKSUM_EN
            chk("checksum", {24'd0, checksum}, {24'd0, m_sum});
`endif
            if (wr) begin
                wr_addr.push_back(int'(addr));
                wr_cyc.push_back(cyc);
            end
            if (clear) n_clr++;
            if (done) n_done++;
        end
    end

    logic [7:0] pat [16];

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Runs one session; abort/start are raised in ACCEPT once 'sent' bytes reach the marks.
    task automatic session(input int abort_at, input int start_at);
        int sent;
        bit hs;
        bit ended;
        sent  = 0;
        ended = 0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        valid = 1'b1;
        for (int c = 0; c < 100 && !ended; c++) begin
            data  = pat[sent % 16];
            abort = (sent == abort_at) && !wr;
            start = (sent == start_at) && !wr;
            #1;
            hs = ready && valid;
            tick(1);
            if (hs) sent++;
            if (!hold) ended = 1;
        end
        valid = 1'b0;
        abort = 1'b0;
        start = 1'b0;
        chk("session_timeout", {31'd0, ended}, 32'd1);
    endtask

    int w0, c0, d0;

    task automatic mark();
        w0 = wr_addr.size();
        c0 = n_clr;
        d0 = n_done;
    endtask

    task automatic check_addrs(input string name, input int n);
        chk({name, "_writes"}, wr_addr.size() - w0, n);
        for (int i = 0; i < n && (w0 + i) < wr_addr.size(); i++)
            chk({name, "_addr"}, wr_addr[w0 + i], i);
        chk({name, "_clear_pulses"}, n_clr - c0, 1);
        chk({name, "_done_pulses"}, n_done - d0, 1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) pat[i] = 8'(i);

        // Reset state, asserted before any clock edge.
        #2;
        chk("rst_hold", {31'd0, hold}, 32'd0);
        chk("rst_write", {31'd0, wr}, 32'd0);
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_count", {27'd0, count}, 32'd0);
        chk("rst_data", {24'd0, rdata}, 32'd0);
        tick(2);
        rst = 1'b0;
        tick(2);

        // Full load of 0x00..0x0F with valid held high.
        mark();
        session(-1, -1);
        check_addrs("full", 16);
        chk("full_count", {27'd0, count}, 32'd16);
        chk("full_hold", {31'd0, hold}, 32'd0);
        if (wr_addr.size() >= w0 + 16)
            chk("full_spacing", wr_cyc[w0 + 15] - wr_cyc[w0], 30);
        tick(3);
        chk("idle_count_held", {27'd0, count}, 32'd16);

        // Abort in ACCEPT after three bytes.
        mark();
        session(3, -1);
        check_addrs("abort3", 3);
        chk("abort3_count", {27'd0, count}, 32'd3);
        tick(2);

        // Abort together with valid on the first ACCEPT cycle.
        mark();
        session(0, -1);
        check_addrs("abort0", 0);
        chk("abort0_count", {27'd0, count}, 32'd0);
        tick(2);

        // Start repeated while busy must not restart the address.
        mark();
        session(4, 2);
        check_addrs("restart", 4);
        chk("restart_count", {27'd0, count}, 32'd4);
        tick(2);

`ifdef RAM_LOADER_CHECKSUM_EN
        pat[0] = 8'hFF;
        pat[1] = 8'h02;
        mark();
        session(2, -1);
        chk("checksum_ff_02", {24'd0, checksum}, 32'h01);
        pat[0] = 8'h00;
        pat[1] = 8'h01;
        tick(2);
`endif

        // Reset in the middle of the write to address 5.
        begin
            bit hit;
            hit   = 0;
            start = 1'b1;
            tick(1);
            start = 1'b0;
            valid = 1'b1;
            for (int c = 0; c < 40 && !hit; c++) begin
                data = 8'($urandom);
                tick(1);
                if (wr && addr == 4'd5) hit = 1;
            end
            chk("reset_reach_addr5", {31'd0, hit}, 32'd1);
            rst = 1'b1;
            #1;
            chk("async_write", {31'd0, wr}, 32'd0);
            chk("async_hold", {31'd0, hold}, 32'd0);
            chk("async_addr", {28'd0, addr}, 32'd0);
            chk("async_data", {24'd0, rdata}, 32'd0);
            chk("async_count", {27'd0, count}, 32'd0);
            valid = 1'b0;
            tick(2);
            rst = 1'b0;
            tick(2);
            chk("post_reset_busy", {31'd0, busy}, 32'd0);
            chk("post_reset_count", {27'd0, count}, 32'd0);
        end

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            start = ($urandom_range(0, 7) == 0);
            abort = ($urandom_range(0, 19) == 0);
            valid = ($urandom_range(0, 2) != 0);
            data  = 8'($urandom);
            tick(1);
        end
        start = 1'b0;
        abort = 1'b0;
        valid = 1'b0;
        tick(4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
